icache_line_fill: RTL and testbench



---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_line_fill.sv | 143 ++++++++++++++
 tb/tb_icache_line_fill.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: default geometry, derived sizes and fill FSM state encoding
// shared by the instruction-cache line-fill engine.
package icache_pkg;

  localparam int BLOCK_BITS  = 512;
  localparam int BEAT_BITS   = 32;
  localparam int ADDR_BITS   = 32;

  localparam int BEATS       = BLOCK_BITS / BEAT_BITS;
  localparam int OFFSET_BITS = $clog2(BLOCK_BITS / 8);
  localparam int BEAT_SEL    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/icache_line_fill.sv
// icache_line_fill: turns an ICache line miss into BEATS sequential word reads,
// assembles the returned beats into one line and presents it to the cache with
// a one-cycle valid pulse.
// Optional feature macro: ICACHE_FILL_CWF_EN (critical word first issue order).
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int BLOCK_BITS = icache_pkg::BLOCK_BITS,
  parameter int BEAT_BITS  = icache_pkg::BEAT_BITS,
  parameter int ADDR_BITS  = icache_pkg::ADDR_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic [ADDR_BITS-1:0]  req_addr_i,
  output logic [BLOCK_BITS-1:0] fill_data_o,
  output logic [ADDR_BITS-1:0]  fill_addr_o,
  output logic                  fill_valid_o,
  output logic                  mem_rd_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic [BEAT_BITS-1:0]  mem_rdata_i,
  input  logic                  mem_rvalid_i
);

  localparam int BEATS       = BLOCK_BITS / BEAT_BITS;
  localparam int OFFSET_BITS = $clog2(BLOCK_BITS / 8);
  localparam int BEAT_SEL    = $clog2(BEATS);
  localparam int WORD_LSB    = $clog2(BEAT_BITS / 8);
  localparam int CNT_W       = BEAT_SEL + 1;

  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  // Slice index of the n-th beat: rotation from the first beat, wrapping in the line.
  function automatic logic [BEAT_SEL-1:0] beat_idx(input logic [BEAT_SEL-1:0] first,
                                                   input logic [BEAT_SEL-1:0] n);
    return first + n;
  endfunction

  fill_state_t                     state_q, state_d;
  logic [ADDR_BITS-1:0]            line_addr_q, line_addr_d;
  logic [CNT_W-1:0]                issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]                recv_cnt_q, recv_cnt_d;
  logic [BEATS-1:0][BEAT_BITS-1:0] line_q, line_d;
  logic [BEAT_SEL-1:0]             first_beat;
  logic                            mem_rd;

`ifdef ICACHE_FILL_CWF_EN
  logic [BEAT_SEL-1:0]             word_off_q, word_off_d;
  logic                            unused_addr_bits;

  assign first_beat       = word_off_q;
  assign unused_addr_bits = ^req_addr_i[WORD_LSB-1:0];
`else
  logic                            unused_addr_bits;

  // Ascending order: every fill starts at offset 0 of the line.
  assign first_beat       = '0;
  assign unused_addr_bits = ^req_addr_i[OFFSET_BITS-1:0];
`endif

  // Issue requests only in FETCH and only until all beats have been accepted.
  assign mem_rd = (state_q == FETCH) && (issue_cnt_q < BEATS_C);

  // Next-state, counter, address-latch and line-assembly logic.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    line_d      = line_q;
`ifdef ICACHE_FILL_CWF_EN
    word_off_d  = word_off_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          line_addr_d = {req_addr_i[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
`ifdef ICACHE_FILL_CWF_EN
          word_off_d  = req_addr_i[OFFSET_BITS-1:WORD_LSB];
`endif
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (mem_rd && mem_ready_i) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        // Responses come back in issue order, so recv_cnt names the slice.
        if (mem_rvalid_i) begin
          line_d[beat_idx(first_beat, recv_cnt_q[BEAT_SEL-1:0])] = mem_rdata_i;
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST_C) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so outputs drop at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_q      <= '0;
`ifdef ICACHE_FILL_CWF_EN
      word_off_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      line_q      <= line_d;
`ifdef ICACHE_FILL_CWF_EN
      word_off_q  <= word_off_d;
`endif
    end
  end

  // Beat address keeps the line's upper bits untouched, so it never leaves the line.
  assign mem_rd_o     = mem_rd;
  assign mem_addr_o   = mem_rd ? {line_addr_q[ADDR_BITS-1:OFFSET_BITS],
                                  beat_idx(first_beat, issue_cnt_q[BEAT_SEL-1:0]),
                                  {WORD_LSB{1'b0}}}
                               : '0;
  assign fill_valid_o = (state_q == RESP);
  assign fill_addr_o  = line_addr_q;
  assign fill_data_o  = line_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: directed self-checking bench for icache_line_fill with a
// small in-order memory model (optional random backpressure and latency).
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         rst_n_i = 1'b1;
  logic         req_i = 1'b0;
  logic [31:0]  req_addr_i = '0;
  logic [511:0] fill_data_o;
  logic [31:0]  fill_addr_o;
  logic         fill_valid_o;
  logic         mem_rd_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ready_i = 1'b1;
  logic [31:0]  mem_rdata_i = '0;
  logic         mem_rvalid_i = 1'b0;

  icache_line_fill dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .req_i        (req_i),
    .req_addr_i   (req_addr_i),
    .fill_data_o  (fill_data_o),
    .fill_addr_o  (fill_addr_o),
    .fill_valid_o (fill_valid_o),
    .mem_rd_o     (mem_rd_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        mq[$];
  logic [31:0] exp_ord[16];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          rx_cnt = 0;
  int          fv_cnt = 0;
  bit          rdy_rand = 1'b0;
  bit          lat_rand = 1'b0;
  bit          stall_pend = 1'b0;
  logic [31:0] stall_addr = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model and monitor: inputs for the current cycle are driven at the
  // falling edge; DUT outputs depend only on state, so they are sampled right after.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n_i) begin
        mq.delete();
        mem_rvalid_i = 1'b0;
        stall_pend   = 1'b0;
      end else begin
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mq[0].addr;
          void'(mq.pop_front());
          rx_cnt++;
        end else begin
          mem_rvalid_i = 1'b0;
          mem_rdata_i  = 32'h0BAD_0BAD;
        end
        mem_ready_i = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        if (stall_pend && mem_rd_o) chk("addr_hold", mem_addr_o, stall_addr);
        stall_pend = mem_rd_o && !mem_ready_i;
        stall_addr = mem_addr_o;
        if (mem_rd_o && mem_ready_i) begin
          if (hs_cnt < 16) chk($sformatf("issue_addr%0d", hs_cnt), mem_addr_o, exp_ord[hs_cnt]);
          else chk("extra_issue", 512'(hs_cnt), 512'd15);
          hs_cnt++;
          mq.push_back('{mem_addr_o, cyc + (lat_rand ? int'($urandom_range(8, 1)) : 1)});
        end
        if (fill_valid_o) fv_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [511:0] line_of(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(4 * k);
    return l;
  endfunction

  // Expected issue sequence for a request address.
  task automatic set_order(input logic [31:0] addr);
    logic [3:0] w;
`ifdef ICACHE_FILL_CWF_EN
    w = addr[5:2];
`else
    w = 4'd0;
`endif
    for (int k = 0; k < 16; k++) begin
      logic [3:0] b;
      b = w + 4'(k);
      exp_ord[k] = {addr[31:6], b, 2'b00};
    end
  endtask

  task automatic start_fill(input logic [31:0] addr, output int start);
    set_order(addr);
    hs_cnt     = 0;
    rx_cnt     = 0;
    req_i      = 1'b1;
    req_addr_i = addr;
    start      = cyc;
  endtask

  task automatic wait_fill(input logic [31:0] base, input int start, input bit chk_lat);
    int t;
    t = 0;
    while (!fill_valid_o && t < 400) begin
      tick();
      t++;
    end
    chk("fill_seen", 512'(fill_valid_o), 512'd1);
    if (fill_valid_o) begin
      if (chk_lat) chk("latency", 512'(cyc - start), 512'd18);
      chk("fill_addr", 512'(fill_addr_o), 512'(base));
      chk("fill_data", fill_data_o, line_of(base));
      chk("issue_count", 512'(hs_cnt), 512'd16);
      chk("recv_count", 512'(rx_cnt), 512'd16);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int st;
    int fv0;

    // Reset state
    #1 rst_n_i = 1'b0;
    #1;
    chk("rst_mem_rd", 512'(mem_rd_o), 512'd0);
    chk("rst_mem_addr", 512'(mem_addr_o), 512'd0);
    chk("rst_fill_valid", 512'(fill_valid_o), 512'd0);
    chk("rst_fill_addr", 512'(fill_addr_o), 512'd0);
    chk("rst_fill_data", fill_data_o, 512'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();
    chk("idle_no_rd", 512'(mem_rd_o), 512'd0);

    // Basic fill, address 0x1234; request address wiggles mid-fill and must be ignored
    fv0 = fv_cnt;
    start_fill(32'h0000_1234, st);
    tick(); tick(); tick();
    req_addr_i = 32'hDEAD_BEEF;
    wait_fill(32'h0000_1200, st, 1'b1);
    req_i = 1'b0;
    tick();
    chk("single_pulse", 512'(fill_valid_o), 512'd0);
    chk("idle_after_fill", 512'(mem_rd_o), 512'd0);
    tick(); tick();
    chk("no_refill", 512'(mem_rd_o), 512'd0);
    chk("data_stable_idle", fill_data_o, line_of(32'h0000_1200));
    chk("pulse_count", 512'(fv_cnt - fv0), 512'd1);

    // Backpressure
    rdy_rand = 1'b1;
    start_fill(32'h0000_1200, st);
    wait_fill(32'h0000_1200, st, 1'b0);
    req_i = 1'b0;
    rdy_rand = 1'b0;
    tick();

    // Variable latency, several outstanding
    lat_rand = 1'b1;
    start_fill(32'h0000_4440, st);
    wait_fill(32'h0000_4440, st, 1'b0);
    req_i = 1'b0;
    lat_rand = 1'b0;
    tick();

    // Back-to-back: req held high through RESP with a new address
    start_fill(32'h0000_1200, st);
    wait_fill(32'h0000_1200, st, 1'b1);
    req_addr_i = 32'h0000_2000;
    set_order(32'h0000_2000);
    hs_cnt = 0;
    rx_cnt = 0;
    tick();
    chk("b2b_gap_valid", 512'(fill_valid_o), 512'd0);
    chk("b2b_gap_rd", 512'(mem_rd_o), 512'd0);
    chk("b2b_gap_addr", 512'(fill_addr_o), 512'h1200);
    chk("b2b_gap_data", fill_data_o, line_of(32'h0000_1200));
    tick();
    chk("b2b_second_rd", 512'(mem_rd_o), 512'd1);
    req_i = 1'b0;
    wait_fill(32'h0000_2000, st, 1'b0);
    tick();

    // Reset in the middle of a fill
    fv0 = fv_cnt;
    start_fill(32'h0000_5000, st);
    begin
      int t;
      t = 0;
      while (rx_cnt < 5 && t < 200) begin
        tick();
        t++;
      end
      chk("rx5_reached", 512'(rx_cnt >= 5), 512'd1);
    end
    @(posedge clk);
    #1;
    rst_n_i = 1'b0;
    req_i   = 1'b0;
    #1;
    chk("abort_mem_rd", 512'(mem_rd_o), 512'd0);
    chk("abort_mem_addr", 512'(mem_addr_o), 512'd0);
    chk("abort_fill_addr", 512'(fill_addr_o), 512'd0);
    chk("abort_fill_data", fill_data_o, 512'd0);
    chk("abort_fill_valid", 512'(fill_valid_o), 512'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick(); tick(); tick();
    chk("abort_no_pulse", 512'(fv_cnt - fv0), 512'd0);
    start_fill(32'h0000_3000, st);
    wait_fill(32'h0000_3000, st, 1'b1);
    req_i = 1'b0;
    tick();

    // Top-of-memory line; with ICACHE_FILL_CWF_EN this is the critical-word case
    start_fill(32'hFFFF_FFF8, st);
    wait_fill(32'hFFFF_FFC0, st, 1'b1);
    req_i = 1'b0;
    tick();

    // Mid-line miss at 0x1238: rotated order when critical word first is built in
    start_fill(32'h0000_1238, st);
    wait_fill(32'h0000_1200, st, 1'b1);
    req_i = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
